// File: rtl/tx_start_conditioner_if.sv
// Pin-side bundle between the board buttons/switches, the start conditioner and the UART transmitter.
interface tx_start_conditioner_if;
    logic       btn_raw;
    logic [7:0] data_sw;
    logic [1:0] baud_sw;
    logic       tx_start;
    logic [7:0] data_out;
    logic [1:0] baud_out;
    logic       busy;

    modport master (
        output btn_raw, data_sw, baud_sw,
        input  tx_start, data_out, baud_out, busy
    );

    modport slave (
        input  btn_raw, data_sw, baud_sw,
        output tx_start, data_out, baud_out, busy
    );
endinterface

// File: rtl/tx_start_conditioner.sv
// Synchronises and debounces the transmit button, fires one start pulse per press with the
// switch settings captured at that press, and locks out re-triggers for one UART frame.
module tx_start_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BAUD_DIV0       = 5208,
    parameter int BAUD_DIV1       = 2604,
    parameter int BAUD_DIV2       = 868,
    parameter int BAUD_DIV3       = 434
) (
    input  logic                   clk,
    input  logic                   reset,
    tx_start_conditioner_if.slave  bus
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRE     = 2'd1,
        HOLD     = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    // Ten-bit frame plus one guard bit; the HOLD state runs from this value down to zero.
    function automatic logic [15:0] holdoff_load(input logic [1:0] sel);
        case (sel)
            2'd0:    return 16'(11 * BAUD_DIV0 - 1);
            2'd1:    return 16'(11 * BAUD_DIV1 - 1);
            2'd2:    return 16'(11 * BAUD_DIV2 - 1);
            default: return 16'(11 * BAUD_DIV3 - 1);
        endcase
    endfunction

    logic             btn_sync1_q, btn_sync2_q;
    logic             stable_q, stable_d;
    logic             stable_prev_q;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             press;

    state_t           state_q, state_d;
    logic [15:0]      hold_q, hold_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       baud_q, baud_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_sync1_q   <= 1'b0;
            btn_sync2_q   <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            db_cnt_q      <= '0;
        end else begin
            btn_sync1_q   <= bus.btn_raw;
            btn_sync2_q   <= btn_sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            db_cnt_q      <= db_cnt_d;
        end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (btn_sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = btn_sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign press = stable_q & ~stable_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            data_q  <= '0;
            baud_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            baud_q  <= baud_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        data_d  = data_q;
        baud_d  = baud_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    data_d  = bus.data_sw;
                    baud_d  = bus.baud_sw;
                    state_d = FIRE;
                end
            end
            FIRE: begin
                // Holdoff uses the captured baud, so switch moves mid-frame cannot stretch or cut it.
                hold_d  = holdoff_load(baud_q);
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_q == 16'd0) begin
                    state_d = WAIT_REL;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            WAIT_REL: begin
                if (!stable_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.tx_start = (state_q == FIRE);
    assign bus.busy     = (state_q == FIRE) || (state_q == HOLD);
    assign bus.data_out = data_q;
    assign bus.baud_out = baud_q;

endmodule
